// File: rtl/vga_fb_writer.sv
// Framebuffer pixel writer: buffered, bounds-checked pixel stores plus a
// whole-frame clear engine, feeding a single stallable memory write port.
module vga_fb_writer #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int PIXEL_W    = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_x,
    input  logic [6:0]         in_y,
    input  logic [PIXEL_W-1:0] in_data,
    input  logic               clear_req,
    input  logic [PIXEL_W-1:0] clear_color,
    input  logic               mem_ready,
    output logic               wr_en,
    output logic [15:0]        wr_address,
    output logic [PIXEL_W-1:0] wr_data,
    output logic               busy,
    output logic [7:0]         err_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [16:0]   TOTAL    = 17'(FB_W * FB_H);
    localparam logic [16:0]   LAST     = TOTAL - 17'd1;
    localparam logic [8:0]    W_LIM    = 9'(FB_W);
    localparam logic [7:0]    H_LIM    = 8'(FB_H);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DRAIN,
        CLEAR
    } state_t;

    state_t state, state_nx;

    logic [15:0]        fifo_addr [FIFO_DEPTH];
    logic [PIXEL_W-1:0] fifo_data [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [AW:0]        count;

    logic               stg_valid;
    logic [15:0]        stg_addr;
    logic [PIXEL_W-1:0] stg_data;

    logic               clear_pend;
    logic [PIXEL_W-1:0] clr_color;
    logic [16:0]        clr_next;
    logic               init_done;

    logic               in_range;
    logic [15:0]        push_addr;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               out_free;
    logic               stg_adv;
    logic               clr_issue;
    logic               clr_last;
    logic               pipe_idle;

    assign in_range   = ({1'b0, in_x} < W_LIM) && ({1'b0, in_y} < H_LIM);
    assign push_addr  = 16'(in_y) * 16'(FB_W) + 16'(in_x);
    assign fifo_empty = (count == '0);
    assign in_ready   = init_done && (count != CNT_FULL)
                        && !clear_pend && (state != CLEAR);
    assign accept     = in_valid && in_ready;
    assign push       = accept && in_range;
    // The output register may take a new write when empty or completing.
    assign out_free   = !wr_en || mem_ready;
    assign stg_adv    = stg_valid && out_free && (state != CLEAR);
    assign pop        = !fifo_empty && (!stg_valid || stg_adv);
    assign clr_issue  = (state == CLEAR) && out_free && (clr_next < TOTAL);
    assign clr_last   = (state == CLEAR) && wr_en && mem_ready
                        && ({1'b0, wr_address} == LAST);
    assign pipe_idle  = fifo_empty && !stg_valid && out_free;
    assign busy       = !fifo_empty || stg_valid || wr_en || clear_pend;

    // in_ready is held off until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) init_done <= 1'b0;
        else          init_done <= 1'b1;
    end

    // FIFO storage; emptiness is tracked by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Staging register between FIFO head and the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= 1'b0;
            stg_addr  <= '0;
            stg_data  <= '0;
        end else if (pop) begin
            stg_valid <= 1'b1;
            stg_addr  <= fifo_addr[rd_ptr];
            stg_data  <= fifo_data[rd_ptr];
        end else if (stg_adv) begin
            stg_valid <= 1'b0;
        end
    end

    // Output register: held while a write is stalled by mem_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
        end else if (clr_issue) begin
            wr_en      <= 1'b1;
            wr_address <= clr_next[15:0];
            wr_data    <= clr_color;
        end else if (stg_adv) begin
            wr_en      <= 1'b1;
            wr_address <= stg_addr;
            wr_data    <= stg_data;
        end else if (out_free) begin
            wr_en      <= 1'b0;
        end
    end

    // Clear request latch; later requests are ignored until the fill ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_pend <= 1'b0;
            clr_color  <= '0;
        end else if (clr_last) begin
            clear_pend <= 1'b0;
        end else if (clear_req && !clear_pend) begin
            clear_pend <= 1'b1;
            clr_color  <= clear_color;
        end
    end

    // Next clear address to issue; rewound before every fill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               clr_next <= '0;
        else if (state != CLEAR)    clr_next <= '0;
        else if (clr_issue)         clr_next <= clr_next + 17'd1;
    end

    // Out-of-range requests are swallowed and counted, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (accept && !in_range && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic: drain buffered pixels before any fill.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (clear_pend)       state_nx = DRAIN;
                else if (!fifo_empty) state_nx = WRITE;
            end
            WRITE: begin
                if (clear_pend)       state_nx = DRAIN;
                else if (pipe_idle)   state_nx = IDLE;
            end
            DRAIN: begin
                if (pipe_idle)        state_nx = CLEAR;
            end
            CLEAR: begin
                if (clr_last)         state_nx = IDLE;
            end
            default:                  state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Scoreboard bench for vga_fb_writer: random and directed pixel writes,
// clears, stalls and resets against a frame-level reference model.
module tb_vga_fb_writer;

    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int PW    = 24;
    localparam int TOTAL = FB_W * FB_H;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_x = '0;
    logic [6:0]    in_y = '0;
    logic [PW-1:0] in_data = '0;
    logic          clear_req = 1'b0;
    logic [PW-1:0] clear_color = '0;
    logic          mem_ready = 1'b1;
    logic          wr_en;
    logic [15:0]   wr_address;
    logic [PW-1:0] wr_data;
    logic          busy;
    logic [7:0]    err_count;

    int            total = 0;
    int            bad = 0;
    logic [39:0]   exp_q[$];
    int            m_err = 0;
    bit            m_clr_pend = 0;
    bit            clr_flag = 0;
    bit            chk_busy = 0;
    bit            prev_hold = 0;
    bit            rand_mr = 0;
    logic [15:0]   h_addr;
    logic [PW-1:0] h_data;

    vga_fb_writer #(
        .FB_W(FB_W), .FB_H(FB_H), .PIXEL_W(PW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_data(in_data),
        .clear_req(clear_req), .clear_color(clear_color),
        .mem_ready(mem_ready),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [39:0] act, logic [39:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference model: a pixel lands at y*W+x if on-screen, else it is counted.
    task automatic model_accept(int x, int y, logic [PW-1:0] d);
        if (x < FB_W && y < FB_H)
            exp_q.push_back({16'(y * FB_W + x), d});
        else if (m_err < 255)
            m_err++;
    endtask

    task automatic send(int x, int y, logic [PW-1:0] d);
        int n = 0;
        in_x = 8'(x);
        in_y = 7'(y);
        in_data = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: x=%0d y=%0d", x, y);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_accept(x, y, d);
        #1;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(logic [PW-1:0] c);
        clear_req = 1'b1;
        clear_color = c;
        @(posedge clk);
        if (!m_clr_pend) begin
            for (int i = 0; i < TOTAL; i++) exp_q.push_back({16'(i), c});
            m_clr_pend = 1;
            clr_flag = 1;
        end
        #1;
        clear_req = 1'b0;
    endtask

    task automatic wait_empty(string name, int budget);
        int n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: drain timeout, %0d writes left", name,
                     exp_q.size());
        end
    endtask

    // Random memory back-pressure, changed just after each rising edge.
    always @(posedge clk) begin
        if (rand_mr) begin
            #1;
            mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks stalls, clear-time in_ready and each completed write.
    always @(negedge clk) begin
        logic [39:0] e;
        if (!reset_n) begin
            prev_hold = 0;
            chk_busy = 0;
        end else begin
            if (prev_hold) begin
                total++;
                if (!(wr_en && wr_address == h_addr && wr_data == h_data)) begin
                    bad++;
                    $display("FAIL hold: got en=%0b addr=%0d data=%h want addr=%0d data=%h",
                             wr_en, wr_address, wr_data, h_addr, h_data);
                end
            end
            if (chk_busy) begin
                chk_busy = 0;
                check("busy_after_clear", 40'(busy), 40'(0));
                check("ready_after_clear", 40'(in_ready), 40'(1));
            end
            if (clr_flag) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_in_clear: got %b want 0", in_ready);
                end
            end
            prev_hold = 0;
            if (wr_en && !mem_ready) begin
                prev_hold = 1;
                h_addr = wr_address;
                h_data = wr_data;
            end else if (wr_en && mem_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h want none",
                             wr_address, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_address, wr_data} !== e) begin
                        bad++;
                        $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                                 wr_address, wr_data, e[39:24], e[23:0]);
                    end
                    if (clr_flag && exp_q.size() == 0) begin
                        clr_flag = 0;
                        chk_busy = 1;
                        m_clr_pend = 0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check("rst_wr_en", 40'(wr_en), 40'(0));
        check("rst_addr", 40'(wr_address), 40'(0));
        check("rst_data", 40'(wr_data), 40'(0));
        check("rst_busy", 40'(busy), 40'(0));
        check("rst_ready", 40'(in_ready), 40'(0));
        check("rst_err", 40'(err_count), 40'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 40'(in_ready), 40'(1));

        // Single write with latency
        send(5, 10, 24'hFF0000);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_c1", 40'(wr_en), 40'(0));
        @(negedge clk);
        check("lat_c2", 40'(wr_en), 40'(0));
        @(negedge clk);
        check("lat_c3", 40'(wr_en), 40'(1));
        check("lat_addr", 40'(wr_address), 40'(1605));
        check("lat_data", 40'(wr_data), 40'(24'hFF0000));
        @(posedge clk);
        #1;
        wait_empty("single", 50);

        // Far corner
        send(159, 119, 24'h00AA55);
        wait_empty("corner", 50);

        // Out of range on each axis
        send(160, 0, 24'h111111);
        send(0, 120, 24'h222222);
        idle(6);
        check("err_two", 40'(err_count), 40'(m_err));

        // Burst into a stalled memory port
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(10 + i, 3, 24'(24'h100 + i));
        in_valid = 1'b0;
        @(negedge clk);
        check("ready_full", 40'(in_ready), 40'(0));
        @(posedge clk);
        #1;
        idle(8);
        mem_ready = 1'b1;
        wait_empty("burst", 100);

        // Random traffic with random back-pressure
        rand_mr = 1;
        for (int i = 0; i < 120; i++) begin
            send($urandom_range(0, 175), $urandom_range(0, 127),
                 24'($urandom));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        in_valid = 1'b0;
        rand_mr = 0;
        idle(1);
        mem_ready = 1'b1;
        wait_empty("random", 1000);
        check("err_random", 40'(err_count), 40'(m_err));

        // Clear behind two buffered pixels; a second request is ignored
        mem_ready = 1'b0;
        send(1, 1, 24'hC0FFEE);
        send(2, 2, 24'hBEEF00);
        in_valid = 1'b0;
        do_clear(24'h0000FF);
        idle(3);
        mem_ready = 1'b1;
        idle(40);
        do_clear(24'h123456);
        wait_empty("clear", 25000);
        idle(2);

        // Saturating error counter
        for (int i = 0; i < 257; i++) send(200, $urandom_range(0, 127), 24'h0);
        idle(4);
        check("err_sat", 40'(err_count), 40'(255));

        // Reset part way through a clear
        do_clear(24'hABCDEF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wr_en && wr_address == 16'd100) && n < 500);
        check("clear_reach_100", 40'(n < 500), 40'(1));
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        clr_flag = 0;
        m_clr_pend = 0;
        m_err = 0;
        check("mid_rst_wr_en", 40'(wr_en), 40'(0));
        check("mid_rst_err", 40'(err_count), 40'(0));
        check("mid_rst_busy", 40'(busy), 40'(0));
        check("mid_rst_ready", 40'(in_ready), 40'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_ready_after", 40'(in_ready), 40'(1));
        idle(40);
        check("mid_busy_after", 40'(busy), 40'(0));

        // Normal service resumes
        send(0, 0, 24'h5A5A5A);
        wait_empty("post_rst", 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
